// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: a small FIFO between the fetch and decode stages.
// Optional same-cycle bypass on an empty queue is enabled with PREFETCH_BYPASS_EN.
module inst_prefetch_queue #(
  parameter int INST_LEN = 17,
  parameter int DEPTH    = 4,
  parameter int PTR_LEN  = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [INST_LEN-1:0] in_inst,
  output logic                in_ready,
  output logic                out_valid,
  output logic [INST_LEN-1:0] out_inst,
  input  logic                out_ready,
  output logic [PTR_LEN:0]    count
);

  logic [INST_LEN-1:0] entries [DEPTH];
  logic [PTR_LEN-1:0]  wr_ptr;
  logic [PTR_LEN-1:0]  rd_ptr;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  assign full     = (count == (PTR_LEN+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full && !flush;

`ifdef PREFETCH_BYPASS_EN
  logic bypass;

  // An instruction arriving at an empty queue while decode is ready skips storage entirely.
  assign bypass    = empty && in_valid && out_ready && !flush;
  assign out_valid = (!empty && !flush) || bypass;
  assign out_inst  = bypass ? in_inst : entries[rd_ptr];
  assign push      = in_valid && in_ready && !bypass;
  assign pop       = out_valid && out_ready && !flush && !bypass;
`else
  assign out_valid = !empty && !flush;
  assign out_inst  = entries[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
`endif

  // Storage needs no reset: stale contents are never visible while out_valid is low.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wr_ptr] <= in_inst;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_LEN'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_LEN'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_LEN+1)'(1);
        2'b01:   count <= count - (PTR_LEN+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed self-checking bench for inst_prefetch_queue (default DEPTH=4, INST_LEN=17).
module tb_inst_prefetch_queue;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic [16:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic [16:0] out_inst;
  logic        out_ready;
  logic [2:0]  count;

  int checks;
  int failures;

  inst_prefetch_queue #(.INST_LEN(17), .DEPTH(4), .PTR_LEN(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change in the low phase; outputs are sampled 1ns later, well away from posedge.
  task automatic applyStimulus(input logic v, input logic [16:0] inst,
                               input logic rdy, input logic fl);
    in_valid  = v;
    in_inst   = inst;
    out_ready = rdy;
    flush     = fl;
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rstn      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    out_ready = 1'b0;
    #1;
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;

    // Fill with decode stalled, then a rejected fifth push
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 17'(k), 1'b0, 1'b0);
      checkOutput("fill_in_ready", 32'(in_ready), 32'd1);
      cycle();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("full_head", 32'(out_inst), 32'h1);
    applyStimulus(1'b1, 17'h5, 1'b0, 1'b0);
    cycle();
    checkOutput("fifth_ignored_count", 32'(count), 32'd4);

    // Pop-only at full reopens in_ready
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("pop1_data", 32'(out_inst), 32'h1);
    cycle();
    checkOutput("pop_full_count", 32'(count), 32'd3);
    checkOutput("pop_full_in_ready", 32'(in_ready), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("drain_valid", 32'(out_valid), 32'd1);
      checkOutput("drain_data", 32'(out_inst), 32'(k));
      cycle();
    end
    checkOutput("drained_out_valid", 32'(out_valid), 32'd0);
    checkOutput("drained_count", 32'(count), 32'd0);

    // Pop attempt on an empty queue changes nothing
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    cycle();
    checkOutput("empty_pop_count", 32'(count), 32'd0);

    // Asynchronous reset with three entries queued
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 17'(32'hA + k), 1'b0, 1'b0);
      cycle();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("prereset_count", 32'(count), 32'd3);
    rstn = 1'b0;
    #1;
    checkOutput("async_reset_count", 32'(count), 32'd0);
    checkOutput("async_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset_in_ready", 32'(in_ready), 32'd1);
    rstn = 1'b1;
    applyStimulus(1'b1, 17'h1ABCD, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("post_reset_valid", 32'(out_valid), 32'd1);
    checkOutput("post_reset_data", 32'(out_inst), 32'h1ABCD);
    checkOutput("post_reset_count", 32'(count), 32'd1);
    cycle();
    checkOutput("post_reset_drain", 32'(count), 32'd0);

    // Steady concurrent push+pop at count=2 with pointer wrap
    applyStimulus(1'b1, 17'h100, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 17'h101, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 17'(32'h200 + i), 1'b1, 1'b0);
      checkOutput("stream_data", 32'(out_inst),
                  (i == 0) ? 32'h100 : (i == 1) ? 32'h101 : 32'h200 + 32'(i - 2));
      cycle();
      checkOutput("stream_count", 32'(count), 32'd2);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("stream_tail0", 32'(out_inst), 32'h208);
    cycle();
    checkOutput("stream_tail1", 32'(out_inst), 32'h209);
    cycle();
    checkOutput("stream_empty", 32'(count), 32'd0);

    // Flush wins over simultaneous push and pop
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 17'(32'h300 + k), 1'b0, 1'b0);
      cycle();
    end
    applyStimulus(1'b1, 17'h3FF, 1'b1, 1'b1);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    cycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("flushed_count", 32'(count), 32'd0);
    checkOutput("flushed_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 17'h310, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("after_flush_data", 32'(out_inst), 32'h310);
    checkOutput("after_flush_count", 32'(count), 32'd1);
    cycle();

    // Empty queue with fetch and decode both ready
    applyStimulus(1'b1, 17'h15555, 1'b1, 1'b0);
`ifdef PREFETCH_BYPASS_EN
    checkOutput("bypass_valid", 32'(out_valid), 32'd1);
    checkOutput("bypass_data", 32'(out_inst), 32'h15555);
    cycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("bypass_count", 32'(count), 32'd0);
    checkOutput("bypass_after_valid", 32'(out_valid), 32'd0);
`else
    checkOutput("nobypass_valid", 32'(out_valid), 32'd0);
    cycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("nobypass_next_valid", 32'(out_valid), 32'd1);
    checkOutput("nobypass_next_data", 32'(out_inst), 32'h15555);
    checkOutput("nobypass_count", 32'(count), 32'd1);
    cycle();
    checkOutput("nobypass_drain", 32'(count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_queue.md
INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Interface
REQ-001 Parameter INST_LEN, default 17, instruction word width in bits.
REQ-002 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two and at least 2.
REQ-003 Parameter PTR_LEN, default 2, pointer width; SHALL equal log2(DEPTH).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous discard of all queued instructions.
REQ-007 in_valid  input  1  upstream fetch stage presents in_inst.
REQ-008 in_inst  input  INST_LEN  instruction from the fetch stage.
REQ-009 in_ready  output  1  queue accepts in_inst this cycle.
REQ-010 out_valid  output  1  out_inst is valid for the decode stage.
REQ-011 out_inst  output  INST_LEN  oldest queued instruction.
REQ-012 out_ready  input  1  decode stage consumes out_inst this cycle.
REQ-013 count  output  PTR_LEN+1  number of occupied entries, 0..DEPTH.

Function
REQ-014 Push SHALL occur on a rising edge when in_valid=1, in_ready=1 and flush=0, writing in_inst at wr_ptr.
REQ-015 Pop SHALL occur on a rising edge when out_valid=1, out_ready=1 and flush=0, advancing rd_ptr.
REQ-016 wr_ptr and rd_ptr SHALL wrap from DEPTH-1 to 0.
REQ-017 count SHALL increment on push-only, decrement on pop-only, and hold on simultaneous push+pop or on neither.
REQ-018 in_ready SHALL be 1 when count<DEPTH and flush=0, and 0 otherwise; pass-through on full SHALL NOT occur.
REQ-019 out_valid SHALL be 1 when count>0 and flush=0 (bypass case: see REQ-028).
REQ-020 out_inst SHALL equal entry[rd_ptr] combinationally; its value SHALL NOT be relied on when out_valid=0.
REQ-021 Without bypass, latency SHALL be 1 cycle: an instruction pushed at edge N SHALL be visible on out_inst after edge N.
REQ-022 Order SHALL be strict FIFO; no instruction SHALL be duplicated or dropped except by flush.
REQ-023 flush=1 SHALL take priority over push and pop in the same cycle; at the next edge, wr_ptr, rd_ptr and count SHALL be 0; entry contents need not be cleared.
REQ-024 At full, simultaneous push+pop SHALL NOT occur, because in_ready=0; a pop alone SHALL reopen in_ready in the following cycle.
REQ-025 At empty, out_ready=1 SHALL have no effect.

Reset
REQ-026 When rstn=0, wr_ptr, rd_ptr and count SHALL be 0 immediately (asynchronous), with out_valid=0 and in_ready=1 when flush=0.
REQ-027 A reset asserted mid-operation SHALL discard all entries; release SHALL be synchronous-safe, and the first push SHALL be accepted on the first edge with rstn=1.

Configuration
REQ-028 Macro PREFETCH_BYPASS_EN, when defined: if count=0, in_valid=1, out_ready=1 and flush=0, then out_valid SHALL be 1 and out_inst SHALL equal in_inst in the same cycle; the instruction SHALL be consumed without being stored, and count, wr_ptr and rd_ptr SHALL be unchanged.
REQ-029 Without PREFETCH_BYPASS_EN, out_valid SHALL depend only on count and flush, and the minimum latency SHALL be 1 cycle.

Verification
REQ-030 Reset check: rstn=0 mid-stream with count=3 -> count=0, out_valid=0 and in_ready=1 with no clock edge; push 0x1ABCD after release -> out_inst=0x1ABCD one cycle later.
REQ-031 Fill and order: push 0x00001, 0x00002, 0x00003, 0x00004 with out_ready=0 -> count=4 and in_ready=0; a fifth push is ignored; then pop 4 -> outputs 1, 2, 3, 4, then out_valid=0.
REQ-032 Wrap and concurrency: steady push+pop every cycle for 10 cycles with count=2 -> count stays 2, pointers wrap, and the 10 values emerge in order.
REQ-033 Flush priority: count=3 and flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, nothing popped, and the pushed word is dropped.
REQ-034 Boundaries: pop at empty -> count stays 0; at full, pop-only -> count=3 and in_ready=1 next cycle.
REQ-035 Bypass, with PREFETCH_BYPASS_EN: empty queue, in_valid=1, out_ready=1, in_inst=0x15555 -> out_valid=1 and out_inst=0x15555 in the same cycle, count stays 0; without the macro -> out_valid=0 that cycle and out_valid=1 next cycle.
